// File: rtl/sram_4x16.sv
// sram_4x16: 16-word x 4-bit register-file SRAM, one-cycle registered read, async active-high clear.
// Optional macro SRAM_4X16_WRITE_THROUGH_EN: out also takes the write data on a write edge.
module sram_4x16 #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] out
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_out;
  logic              w_ctl_ok;
  logic              w_wr_en;
  logic              w_rd_en;

  // Unknown control leaves both the array and the read register untouched.
  assign w_ctl_ok = !$isunknown({wr, addr});
  assign w_wr_en  = w_ctl_ok && wr;
  assign w_rd_en  = w_ctl_ok && !wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[addr] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_rd_en) begin
      r_out <= r_mem[addr];
`ifdef SRAM_4X16_WRITE_THROUGH_EN
    end else if (w_wr_en) begin
      r_out <= data;
`endif
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_sram_4x16.sv
// Scoreboard bench for sram_4x16: driver queues hand-computed expected out values, negedge monitor checks them.
module tb_sram_4x16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0;
  logic [3:0] data = 4'd0;
  logic [3:0] addr = 4'd0;
  logic [3:0] out;

  always #5 clk = ~clk;

  sram_4x16 #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr),
    .data (data),
    .addr (addr),
    .out  (out)
  );

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [3:0] exp_q[$];
  string      tag_q[$];
  logic [3:0] m_out = 4'd0;
  logic [3:0] mon_exp;
  string      mon_tag;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each edge that carried an operation has one queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check(mon_tag, out, mon_exp);
    end
  end

  task automatic do_op(input logic w, input logic [3:0] a, input logic [3:0] d,
                       input logic [3:0] e, input string t);
    wr   = w;
    addr = a;
    data = d;
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] e);
    m_out = e;
    do_op(1'b0, a, 4'd0, e, $sformatf("rd_a%0d", a));
  endtask

  task automatic wrt(input logic [3:0] a, input logic [3:0] d);
`ifdef SRAM_4X16_WRITE_THROUGH_EN
    m_out = d;
`endif
    do_op(1'b1, a, d, m_out, $sformatf("wr_a%0d_out", a));
  endtask

  initial begin
    // Reset asserted with a pending write to 15 that must be ignored.
    wr = 1'b1; addr = 4'd15; data = 4'b0110;
    #2 rst = 1'b1;
    #1 check("rst_async_out", out, 4'b0000);
    repeat (2) @(posedge clk);
    #1 check("rst_held_out", out, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    rd(4'd15, 4'b0000);
    rd(4'd0, 4'b0000);

    // Fill with 15-i, then sweep reads.
    for (int i = 0; i < 16; i++) wrt(4'(i), 4'(15 - i));
    for (int i = 0; i < 16; i++) rd(4'(i), 4'(15 - i));

    // Overwrite, neighbour untouched.
    wrt(4'd3, 4'b1010);
    wrt(4'd3, 4'b0101);
    rd(4'd3, 4'b0101);
    rd(4'd4, 4'd11);

    // Read then write: out holds (or follows data with write-through).
    rd(4'd5, 4'd10);
    wrt(4'd6, 4'b0011);
    rd(4'd6, 4'b0011);
    wrt(4'd7, 4'b0010);
    rd(4'd7, 4'b0010);
    rd(4'd8, 4'd7);

    // Mid-cycle glitch on inputs must not write.
    wr = 1'b1; addr = 4'd0; data = 4'd7;
    #2;
    rd(4'd0, 4'd15);

    // Async reset pulse between edges clears out and the array.
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_pulse_out", out, 4'b0000);
    #1 rst = 1'b0;
    #1 check("rst_release_out", out, 4'b0000);
    rd(4'd9, 4'b0000);
    rd(4'd0, 4'b0000);
    rd(4'd15, 4'b0000);

    // Unknown address on a write edge changes nothing.
    for (int i = 0; i < 16; i++) wrt(4'(i), 4'b1001);
    rd(4'd0, 4'b1001);
    wr = 1'b1; addr = 4'bxxxx; data = 4'b1001;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) rd(4'(i), 4'b1001);

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time=%0t limit=20000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_4x16.md
SRAM_4X16 -- requirements
Module: sram_4x16

Interface
REQ-001 Parameter DATA_W, default 4, word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W = 16 words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr  input  1  1 = write cycle, 0 = read cycle.
REQ-006 data  input  DATA_W  write data.
REQ-007 addr  input  ADDR_W  word address for read or write.
REQ-008 out  output  DATA_W  registered read data.

Function
REQ-009 Storage SHALL be a 16 x 4-bit array, each word individually addressable by addr (0..15, no wrap, no unused codes).
REQ-010 Write: on rising clk with rst=0 and wr=1, mem[addr] SHALL take data; the new value is readable from the next read cycle onward.
REQ-011 Read: on rising clk with rst=0 and wr=0, out SHALL take mem[addr]; latency is one cycle (valid after that edge, stable until the next updating edge).
REQ-012 In a write cycle, out SHALL hold its previous value (unless REQ-019 applies).
REQ-013 If addr or wr contains X/Z at a rising edge, memory SHALL NOT be modified and out SHALL hold its value.
REQ-014 Consecutive cycles SHALL be independent: back-to-back writes, back-to-back reads and write-then-read of the same address each take one cycle with no stall.
REQ-015 Inputs SHALL be sampled only at the rising clk edge; changes between edges have no effect.

Reset
REQ-016 While rst=1, out SHALL be 4'b0000 and all 16 memory words SHALL be 4'b0000, asserted immediately without waiting for clk.
REQ-017 Writes and reads presented while rst=1 SHALL be ignored, including a cycle with wr=1.
REQ-018 After rst deasserts, the first rising edge SHALL perform a normal read or write.

Configuration
REQ-019 Macro SRAM_4X16_WRITE_THROUGH_EN: when defined, out SHALL also take data on a write edge (rst=0, wr=1), giving same-cycle write-through; when undefined, out SHALL hold during writes per REQ-012.

Verification
REQ-020 Assert rst=1 with wr=1, addr=4'b1111, data=4'b0110; release rst, read addr 15 -> out=4'b0000 (write ignored, memory cleared).
REQ-021 Write addr i with data 15-i for i=0..15, then read addr 0..15 -> out equals 15-i one cycle after each read edge (0->1111, 15->0000).
REQ-022 Write addr 3 = 4'b1010, then write addr 3 = 4'b0101, read addr 3 -> 4'b0101; read addr 4 -> unchanged previous contents.
REQ-023 After filling memory, pulse rst between clock edges -> out and a read of any address return 4'b0000 immediately and on the next read.
REQ-024 Read addr 5 (out=value v), then write addr 6 = 4'b0011 -> out stays v without SRAM_4X16_WRITE_THROUGH_EN, becomes 4'b0011 with it defined.
REQ-025 Drive addr=X with wr=1 at an edge -> no word changes; subsequent full read sweep matches prior contents.
